// File: rtl/sat_addsub_pkg.sv
// Shared opcodes and saturation-limit helpers for the saturating add/sub pipeline.
package sat_addsub_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    // Limits are built at 64 bits and truncated to the datapath width by the caller.
    function automatic logic [63:0] sat_max_val(input int unsigned width);
        sat_max_val = (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min_val(input int unsigned width);
        sat_min_val = 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/cla_adder_n.sv
// N-bit carry-lookahead adder from 4-bit lookahead groups with rippled group carries.
module cla_adder_n #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         pg,
    output logic         gg
);

    localparam int unsigned NGRP = (N + 3) / 4;
    localparam int unsigned NP   = NGRP * 4;

    logic [NP-1:0]   p;
    logic [NP-1:0]   g;
    logic [NP:0]     c;
    logic [NGRP-1:0] grp_p;
    logic [NGRP-1:0] grp_g;

    // Pad bits propagate so the top carry and group terms reflect only the real bits.
    always_comb begin
        p        = '1;
        g        = '0;
        p[N-1:0] = x ^ y;
        g[N-1:0] = x & y;
    end

    assign c[0] = cin;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        localparam int unsigned B = 4 * k;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign grp_g[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                        | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign grp_p[k] = &p[B+3:B];
        assign c[B+4]   = grp_g[k] | (grp_p[k] & c[B]);
    end

    assign sum  = p[N-1:0] ^ c[N-1:0];
    assign cout = c[NP];
    assign pg   = &grp_p;

    always_comb begin
        gg = 1'b0;
        for (int k = 0; k < int'(NGRP); k++) begin
            gg = grp_g[k] | (grp_p[k] & gg);
        end
    end

endmodule

// File: rtl/sat_addsub_pipe.sv
// Two-stage signed add/sub/accumulate unit with saturation and valid/ready flow control.
// WIDTH must be even and at least 4; the low half is summed in S1, the high half in S2.
module sat_addsub_pipe
    import sat_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter bit          SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovfl,
    output logic [WIDTH-1:0] acc,
    output logic             sticky_ovfl,
    input  logic             clr_sticky
);

    localparam int unsigned H = WIDTH / 2;
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max_val(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min_val(WIDTH));

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [H-1:0]     lo_sum;
    logic             lo_cout;
    logic             lo_pg;
    logic             lo_gg;

    logic             s1_valid;
    logic [H-1:0]     s1_lo;
    logic             s1_c;
    logic [H-1:0]     s1_xh;
    logic [H-1:0]     s1_yh;
    logic [1:0]       s1_op;

    logic [H-1:0]     hi_sum;
    logic             hi_cout;
    logic             hi_pg;
    logic             hi_gg;
    logic             s2_ovfl;
    logic [WIDTH-1:0] s2_res;

    logic             s2_load;
    logic             accept;
    logic             unused_bits;

    always_comb begin
        x   = a;
        y   = b;
        cin = 1'b0;
        unique case (op)
            OP_ADD:  begin x = a;   y = b;  cin = 1'b0; end
            OP_SUB:  begin x = a;   y = ~b; cin = 1'b1; end
            OP_ACC:  begin x = acc; y = a;  cin = 1'b0; end
            OP_LOAD: begin x = a;   y = '0; cin = 1'b0; end
            default: begin x = a;   y = b;  cin = 1'b0; end
        endcase
    end

    cla_adder_n #(.N(H)) u_lo_add (
        .x    (x[H-1:0]),
        .y    (y[H-1:0]),
        .cin  (cin),
        .sum  (lo_sum),
        .cout (lo_cout),
        .pg   (lo_pg),
        .gg   (lo_gg)
    );

    cla_adder_n #(.N(H)) u_hi_add (
        .x    (s1_xh),
        .y    (s1_yh),
        .cin  (s1_c),
        .sum  (hi_sum),
        .cout (hi_cout),
        .pg   (hi_pg),
        .gg   (hi_gg)
    );

    assign unused_bits = ^{lo_pg, lo_gg, hi_cout, hi_pg, hi_gg, s1_op[0]};

    assign s2_load  = s1_valid & (~out_valid | out_ready);
    // An accumulator op in S1 has not yet written acc, so a following ACC/LOAD must wait.
    assign in_ready = (~s1_valid | s2_load) & ~(s1_valid & s1_op[1] & op[1]);
    assign accept   = in_valid & in_ready;

    assign s2_ovfl = (s1_xh[H-1] == s1_yh[H-1]) & (hi_sum[H-1] != s1_xh[H-1]);

    always_comb begin
        s2_res = {hi_sum, s1_lo};
        if (SAT && s2_ovfl) begin
            s2_res = s1_xh[H-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_c     <= 1'b0;
            s1_xh    <= '0;
            s1_yh    <= '0;
            s1_op    <= OP_ADD;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_lo    <= lo_sum;
                s1_c     <= lo_cout;
                s1_xh    <= x[WIDTH-1:H];
                s1_yh    <= y[WIDTH-1:H];
                s1_op    <= op;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            result      <= '0;
            ovfl        <= 1'b0;
            acc         <= '0;
            sticky_ovfl <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                result    <= s2_res;
                ovfl      <= s2_ovfl;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (s2_load && s1_op[1]) begin
                acc <= s2_res;
            end
            if (s2_load && s2_ovfl) begin
                sticky_ovfl <= 1'b1;
            end else if (clr_sticky) begin
                sticky_ovfl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Directed bench for sat_addsub_pipe: a saturating instance and a wrapping instance share stimulus.
module tb_sat_addsub_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_ready;
    logic        clr_sticky;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;
    logic        ovfl;
    logic [15:0] acc;
    logic        sticky_ovfl;

    logic        in_ready_w;
    logic        out_valid_w;
    logic [15:0] result_w;
    logic        ovfl_w;
    logic [15:0] acc_w;
    logic        sticky_w;

    int errors;
    int checks;

    sat_addsub_pipe #(.WIDTH(16), .SAT(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .ovfl        (ovfl),
        .acc         (acc),
        .sticky_ovfl (sticky_ovfl),
        .clr_sticky  (clr_sticky)
    );

    sat_addsub_pipe #(.WIDTH(16), .SAT(1'b0)) dut_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready_w),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid_w),
        .out_ready   (out_ready),
        .result      (result_w),
        .ovfl        (ovfl_w),
        .acc         (acc_w),
        .sticky_ovfl (sticky_w),
        .clr_sticky  (clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [15:0] aa, input logic [15:0] bb);
        in_valid = 1'b1;
        op       = o;
        a        = aa;
        b        = bb;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        op         = 2'b00;
        a          = '0;
        b          = '0;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL rst_result got=%h exp=0000", result); end
        checks++; if (ovfl !== 1'b0) begin errors++; $display("FAIL rst_ovfl got=%b exp=0", ovfl); end
        checks++; if (acc !== 16'h0000) begin errors++; $display("FAIL rst_acc got=%h exp=0000", acc); end
        checks++; if (sticky_ovfl !== 1'b0) begin errors++; $display("FAIL rst_sticky got=%b exp=0", sticky_ovfl); end
        checks++; if (acc_w !== 16'h0000 || sticky_w !== 1'b0) begin errors++; $display("FAIL rst_wrap got acc=%h sticky=%b exp 0000/0", acc_w, sticky_w); end
        #1 rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || in_ready_w !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b/%b exp=1/1", in_ready, in_ready_w); end
    endtask

    task automatic test_add_ovfl();
        issue(2'b00, 16'h7FF0, 16'h0020);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency got out_valid=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_valid_w !== 1'b1) begin errors++; $display("FAIL add_valid got=%b/%b exp=1/1", out_valid, out_valid_w); end
        checks++; if (result !== 16'h7FFF) begin errors++; $display("FAIL add_sat_result got=%h exp=7fff", result); end
        checks++; if (ovfl !== 1'b1) begin errors++; $display("FAIL add_ovfl got=%b exp=1", ovfl); end
        checks++; if (sticky_ovfl !== 1'b1) begin errors++; $display("FAIL add_sticky got=%b exp=1", sticky_ovfl); end
        checks++; if (result_w !== 16'h8010 || ovfl_w !== 1'b1) begin errors++; $display("FAIL add_wrap got=%h/%b exp=8010/1", result_w, ovfl_w); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_sub();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        issue(2'b01, 16'h8000, 16'h0001);
        tick();
        issue(2'b01, 16'h1234, 16'h1234);
        tick();
        in_valid = 1'b0;
        checks++; if (result !== 16'h8000 || ovfl !== 1'b1) begin errors++; $display("FAIL sub_neg_sat got=%h/%b exp=8000/1", result, ovfl); end
        checks++; if (result_w !== 16'h7FFF || ovfl_w !== 1'b1) begin errors++; $display("FAIL sub_neg_wrap got=%h/%b exp=7fff/1", result_w, ovfl_w); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_b2b_valid got=%b exp=1", out_valid); end
        checks++; if (result !== 16'h0000 || ovfl !== 1'b0) begin errors++; $display("FAIL sub_zero got=%h/%b exp=0000/0", result, ovfl); end
        checks++; if (result_w !== 16'h0000 || ovfl_w !== 1'b0) begin errors++; $display("FAIL sub_zero_wrap got=%h/%b exp=0000/0", result_w, ovfl_w); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain got out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_acc_hazard();
        issue(2'b11, 16'h0005, 16'h0000);
        tick();
        op = 2'b00;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL acc_add_nostall got in_ready=%b exp=1", in_ready); end
        issue(2'b10, 16'h0003, 16'h0000);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL acc_hazard got in_ready=%b exp=0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL acc_bubble_end got in_ready=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b1 || result !== 16'h0005) begin errors++; $display("FAIL acc_load_res got=%b/%h exp=1/0005", out_valid, result); end
        checks++; if (acc !== 16'h0005) begin errors++; $display("FAIL acc_after_load got=%h exp=0005", acc); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL acc_gap got out_valid=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || result !== 16'h0008 || ovfl !== 1'b0) begin errors++; $display("FAIL acc_sum got=%b/%h/%b exp=1/0008/0", out_valid, result, ovfl); end
        checks++; if (acc !== 16'h0008) begin errors++; $display("FAIL acc_final got=%h exp=0008", acc); end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        issue(2'b00, 16'd1, 16'd1);
        tick();
        issue(2'b00, 16'd2, 16'd2);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_second_ready got=%b exp=1", in_ready); end
        tick();
        issue(2'b00, 16'd3, 16'd3);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got in_ready=%b exp=0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 16'd2) begin errors++; $display("FAIL bp_hold1 got=%b/%b/%h exp=0/1/0002", in_ready, out_valid, result); end
        tick();
        checks++; if (out_valid !== 1'b1 || result !== 16'd2) begin errors++; $display("FAIL bp_hold2 got=%b/%h exp=1/0002", out_valid, result); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 16'd4) begin errors++; $display("FAIL bp_res2 got=%b/%h exp=1/0004", out_valid, result); end
        tick();
        checks++; if (out_valid !== 1'b1 || result !== 16'd6) begin errors++; $display("FAIL bp_res3 got=%b/%h exp=1/0006", out_valid, result); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_sticky_clr();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        checks++; if (sticky_ovfl !== 1'b0) begin errors++; $display("FAIL sticky_pre_clear got=%b exp=0", sticky_ovfl); end
        issue(2'b00, 16'h7FFF, 16'h0001);
        tick();
        in_valid   = 1'b0;
        clr_sticky = 1'b1;
        tick();
        checks++; if (sticky_ovfl !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got=%b exp=1", sticky_ovfl); end
        checks++; if (result !== 16'h7FFF || ovfl !== 1'b1) begin errors++; $display("FAIL sticky_res got=%h/%b exp=7fff/1", result, ovfl); end
        tick();
        clr_sticky = 1'b0;
        checks++; if (sticky_ovfl !== 1'b0) begin errors++; $display("FAIL sticky_clear got=%b exp=0", sticky_ovfl); end
    endtask

    task automatic test_reset_mid();
        issue(2'b11, 16'h0010, 16'h0000);
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (acc !== 16'h0010) begin errors++; $display("FAIL rmid_acc_setup got=%h exp=0010", acc); end
        tick();
        out_ready = 1'b0;
        issue(2'b00, 16'd1, 16'd2);
        tick();
        issue(2'b00, 16'd3, 16'd4);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 16'd3) begin errors++; $display("FAIL rmid_inflight got=%b/%h exp=1/0003", out_valid, result); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (acc !== 16'h0000 || result !== 16'h0000) begin errors++; $display("FAIL rmid_clear got acc=%h res=%h exp 0000/0000", acc, result); end
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale cycle=%0d got out_valid=%b exp=0", i, out_valid); end
            tick();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_add_ovfl();
        test_sub();
        test_acc_hazard();
        test_back_to_back();
        test_sticky_clr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
